// File: rtl/avalon_mm_regfile_if.sv
// Avalon-MM bus bundle for the register file slave.
// master drives address/read/write/writedata/byteenable; slave returns stall and responses.
interface avalon_mm_regfile_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0]   address;
  logic                read;
  logic                write;
  logic [DATA_W-1:0]   writedata;
  logic [DATA_W/8-1:0] byteenable;
  logic                waitrequest;
  logic [DATA_W-1:0]   readdata;
  logic                readdatavalid;
  logic                writeresponsevalid;
  logic [1:0]          response;

  modport master (
    output address, read, write, writedata, byteenable,
    input  waitrequest, readdata, readdatavalid,
    input  writeresponsevalid, response
  );

  modport slave (
    input  address, read, write, writedata, byteenable,
    output waitrequest, readdata, readdatavalid,
    output writeresponsevalid, response
  );
endinterface

// File: rtl/avalon_mm_regfile_slave.sv
// Avalon-MM RW register file with wait states, pipelined responses and RO counters.
// Ports: clk, reset (sync, active-high), bus (slave modport of avalon_mm_regfile_if).
module avalon_mm_regfile_slave #(
  parameter int DATA_W       = 32,
  parameter int ADDR_W       = 8,
  parameter int NUM_REGS     = 16,
  parameter int WAIT_CYCLES  = 2,
  parameter int READ_LATENCY = 2
) (
  input  logic clk,
  input  logic reset,
  avalon_mm_regfile_if.slave bus
);
  localparam int BE_W  = DATA_W / 8;
  localparam int IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam int L     = READ_LATENCY;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_WAIT   = 2'd1;
  localparam logic [1:0] S_ACCEPT = 2'd2;

  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] SLVERR = 2'b10;

  localparam logic [ADDR_W-1:0] A_XFER = ADDR_W'(NUM_REGS);
  localparam logic [ADDR_W-1:0] A_ERR  = ADDR_W'(NUM_REGS + 1);
  localparam logic [3:0]        WC     = 4'(WAIT_CYCLES);

  logic [1:0]        state, state_nx;
  logic [3:0]        cnt;
  logic              wait_q;
  logic [DATA_W-1:0] regs [NUM_REGS];
  logic [DATA_W-1:0] xfer_count;
  logic [DATA_W-1:0] err_count;

  logic              cmd, acc, both, in_rng, err, do_wr;
  logic [IDX_W-1:0]  idx;
  logic [DATA_W-1:0] rd_val;

  logic              p_rv   [L];
  logic              p_wv   [L];
  logic [1:0]        p_resp [L];
  logic [DATA_W-1:0] p_data [L];

  assign cmd    = bus.read | bus.write;
  assign acc    = (state == S_ACCEPT) && cmd;
  assign both   = bus.read & bus.write;
  assign in_rng = bus.address < A_XFER;
  assign idx    = bus.address[IDX_W-1:0];
  assign do_wr  = acc & bus.write & ~bus.read & in_rng;

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:
        if (cmd)
          state_nx = (WC == 4'd0) ? S_ACCEPT : S_WAIT;
      S_WAIT:
        if (!cmd)
          state_nx = S_IDLE;
        else if (cnt == 4'd1)
          state_nx = S_ACCEPT;
      S_ACCEPT:
        state_nx = S_IDLE;
      default:
        state_nx = S_IDLE;
    endcase
  end

  // Read value is taken from the pre-update state of regs/counters.
  always_comb begin
    rd_val = '0;
    err    = 1'b0;
    if (both)
      err = 1'b1;
    else if (bus.write)
      err = ~in_rng;
    else if (in_rng)
      rd_val = regs[idx];
    else if (bus.address == A_XFER)
      rd_val = xfer_count;
    else if (bus.address == A_ERR)
      rd_val = err_count;
    else
      err = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= S_IDLE;
      cnt    <= 4'd0;
      wait_q <= 1'b1;
    end else begin
      state  <= state_nx;
      wait_q <= (state_nx != S_ACCEPT);
      if (state == S_IDLE)
        cnt <= WC;
      else if (state == S_WAIT)
        cnt <= cnt - 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int r = 0; r < NUM_REGS; r++)
        regs[r] <= '0;
      xfer_count <= '0;
      err_count  <= '0;
    end else if (acc) begin
      xfer_count <= xfer_count + DATA_W'(1);
      if (err && (err_count != '1))
        err_count <= err_count + DATA_W'(1);
      if (do_wr)
        for (int i = 0; i < BE_W; i++)
          if (bus.byteenable[i])
            regs[idx][8*i +: 8] <= bus.writedata[8*i +: 8];
    end
  end

  // Data only advances behind a read strobe so readdata holds between reads.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int s = 0; s < L; s++) begin
        p_rv[s]   <= 1'b0;
        p_wv[s]   <= 1'b0;
        p_resp[s] <= OKAY;
        p_data[s] <= '0;
      end
    end else begin
      p_rv[0]   <= acc & bus.read;
      p_wv[0]   <= acc & bus.write;
      p_resp[0] <= (acc && err) ? SLVERR : OKAY;
      if (acc & bus.read)
        p_data[0] <= rd_val;
      for (int s = 1; s < L; s++) begin
        p_rv[s]   <= p_rv[s-1];
        p_wv[s]   <= p_wv[s-1];
        p_resp[s] <= p_resp[s-1];
        if (p_rv[s-1])
          p_data[s] <= p_data[s-1];
      end
    end
  end

  assign bus.waitrequest        = wait_q;
  assign bus.readdatavalid      = p_rv[L-1];
  assign bus.writeresponsevalid = p_wv[L-1];
  assign bus.response           = p_resp[L-1];
  assign bus.readdata           = p_data[L-1];
endmodule

// File: tb/tb_avalon_mm_regfile_slave.sv
// Testbench for avalon_mm_regfile_slave: vector table, random ops vs model,
// reset/abort corner cases and a WAIT_CYCLES=0/READ_LATENCY=1 instance.
module tb_avalon_mm_regfile_slave;
  localparam int WC = 2;
  localparam int RL = 2;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  int   cyc   = 0;
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  avalon_mm_regfile_if #(.ADDR_W(8), .DATA_W(32)) bus0 ();
  avalon_mm_regfile_if #(.ADDR_W(8), .DATA_W(32)) bus1 ();

  avalon_mm_regfile_slave #(
    .DATA_W(32), .ADDR_W(8), .NUM_REGS(16),
    .WAIT_CYCLES(WC), .READ_LATENCY(RL)
  ) dut0 (
    .clk(clk), .reset(reset), .bus(bus0)
  );

  avalon_mm_regfile_slave #(
    .DATA_W(32), .ADDR_W(8), .NUM_REGS(16),
    .WAIT_CYCLES(0), .READ_LATENCY(1)
  ) dut1 (
    .clk(clk), .reset(reset), .bus(bus1)
  );

  typedef struct {
    logic        r;
    logic        w;
    logic [7:0]  a;
    logic [31:0] d;
    logic [3:0]  be;
    logic [31:0] exp_rd;
    logic [1:0]  exp_resp;
  } vec_t;

  vec_t tbl [13];

  logic [31:0] mregs [16];
  logic [31:0] mxfer;
  logic [31:0] merr;

  task automatic check(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 16; i++) mregs[i] = '0;
    mxfer = '0;
    merr  = '0;
  endtask

  task automatic model_op(input logic r, input logic w,
                          input logic [7:0] a, input logic [31:0] d,
                          input logic [3:0] be,
                          output logic [31:0] ed, output logic [1:0] er);
    logic bad;
    bad = (r && w) || (a >= 8'd18) || (w && a >= 8'd16);
    ed  = '0;
    if (r && !w && !bad)
      ed = (a < 8'd16) ? mregs[a[3:0]] : (a == 8'd16) ? mxfer : merr;
    if (w && !r && a < 8'd16)
      for (int i = 0; i < 4; i++)
        if (be[i]) mregs[a[3:0]][8*i +: 8] = d[8*i +: 8];
    mxfer = mxfer + 32'd1;
    if (bad && merr != 32'hFFFF_FFFF) merr = merr + 32'd1;
    er = bad ? 2'b10 : 2'b00;
  endtask

  task automatic xfer(input logic r, input logic w,
                      input logic [7:0] a, input logic [31:0] d,
                      input logic [3:0] be,
                      output logic [31:0] rd, output logic [1:0] rsp,
                      output logic rv, output logic wv,
                      output int al, output int rl);
    int c0, ca, k;
    rd = '0; rsp = '0; rv = 1'b0; wv = 1'b0; al = -1; rl = -1;
    @(negedge clk);
    bus0.read = r; bus0.write = w; bus0.address = a;
    bus0.writedata = d; bus0.byteenable = be;
    c0 = cyc; k = 0;
    while (bus0.waitrequest && k < 40) begin
      @(negedge clk); k++;
    end
    ca = cyc;
    if (!bus0.waitrequest) al = ca - c0;
    @(negedge clk);
    bus0.read = 1'b0; bus0.write = 1'b0;
    k = 0;
    while (!(bus0.readdatavalid || bus0.writeresponsevalid) && k < 20) begin
      @(negedge clk); k++;
    end
    if (bus0.readdatavalid || bus0.writeresponsevalid) begin
      rl  = cyc - ca;
      rd  = bus0.readdata;
      rsp = bus0.response;
      rv  = bus0.readdatavalid;
      wv  = bus0.writeresponsevalid;
    end
    @(negedge clk);
    check("strobe_one_cycle",
          64'({bus0.readdatavalid, bus0.writeresponsevalid}), 64'(0));
  endtask

  task automatic do_op(input logic r, input logic w,
                       input logic [7:0] a, input logic [31:0] d,
                       input logic [3:0] be,
                       output logic [31:0] rd, output logic [1:0] rsp);
    logic rv, wv;
    int al, rl;
    logic [31:0] ed;
    logic [1:0] er;
    xfer(r, w, a, d, be, rd, rsp, rv, wv, al, rl);
    model_op(r, w, a, d, be, ed, er);
    check($sformatf("acc_lat a=%0d", a), 64'(al), 64'(WC + 1));
    check($sformatf("rsp_lat a=%0d", a), 64'(rl), 64'(RL));
    check($sformatf("rvalid a=%0d", a), 64'(rv), 64'(r));
    check($sformatf("wvalid a=%0d", a), 64'(wv), 64'(w));
    check($sformatf("resp a=%0d", a), 64'(rsp), 64'(er));
    if (r)
      check($sformatf("rdata a=%0d", a), 64'(rd), 64'(ed));
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    model_reset();
  endtask

  task automatic watch_quiet(input string nm, input int n);
    int nst, nwl;
    nst = 0; nwl = 0;
    for (int k = 0; k < n; k++) begin
      if (bus0.readdatavalid || bus0.writeresponsevalid) nst++;
      if (!bus0.waitrequest) nwl++;
      @(negedge clk);
    end
    check({nm, "_strobes"}, 64'(nst), 64'(0));
    check({nm, "_accepts"}, 64'(nwl), 64'(0));
  endtask

  initial begin
    logic [31:0] rd, last_rd;
    logic [1:0]  rsp;
    int          k, kind, c0;
    logic [7:0]  a;
    logic        r, w;
    int          accs[$];
    int          rdvs[$];

    tbl[0]  = '{1'b0, 1'b1, 8'd1,   32'hA5A5_00B5, 4'hF, 32'h0,         2'b00};
    tbl[1]  = '{1'b1, 1'b0, 8'd1,   32'h0,         4'hF, 32'hA5A5_00B5, 2'b00};
    tbl[2]  = '{1'b0, 1'b1, 8'd2,   32'hFFFF_FFFF, 4'hF, 32'h0,         2'b00};
    tbl[3]  = '{1'b0, 1'b1, 8'd2,   32'h1234_5678, 4'h5, 32'h0,         2'b00};
    tbl[4]  = '{1'b1, 1'b0, 8'd2,   32'h0,         4'hF, 32'hFF34_FF78, 2'b00};
    tbl[5]  = '{1'b0, 1'b1, 8'd16,  32'hDEAD_BEEF, 4'hF, 32'h0,         2'b10};
    tbl[6]  = '{1'b1, 1'b0, 8'd16,  32'h0,         4'hF, 32'd6,         2'b00};
    tbl[7]  = '{1'b1, 1'b0, 8'd200, 32'h0,         4'hF, 32'h0,         2'b10};
    tbl[8]  = '{1'b1, 1'b1, 8'd3,   32'h1111_2222, 4'hF, 32'h0,         2'b10};
    tbl[9]  = '{1'b1, 1'b0, 8'd3,   32'h0,         4'hF, 32'h0,         2'b00};
    tbl[10] = '{1'b1, 1'b0, 8'd17,  32'h0,         4'hF, 32'd3,         2'b00};
    tbl[11] = '{1'b0, 1'b1, 8'd4,   32'hCAFE_F00D, 4'h0, 32'h0,         2'b00};
    tbl[12] = '{1'b1, 1'b0, 8'd4,   32'h0,         4'hF, 32'h0,         2'b00};

    bus0.read = 1'b0; bus0.write = 1'b0; bus0.address = '0;
    bus0.writedata = '0; bus0.byteenable = '0;
    bus1.read = 1'b0; bus1.write = 1'b0; bus1.address = '0;
    bus1.writedata = '0; bus1.byteenable = '0;
    model_reset();
    repeat (3) @(negedge clk);
    reset = 1'b0;

    check("rst_waitrequest", 64'(bus0.waitrequest), 64'(1));
    check("rst_rdv", 64'(bus0.readdatavalid), 64'(0));
    check("rst_wrv", 64'(bus0.writeresponsevalid), 64'(0));
    check("rst_readdata", 64'(bus0.readdata), 64'(0));
    check("rst_response", 64'(bus0.response), 64'(0));
    check("rst_waitrequest_b", 64'(bus1.waitrequest), 64'(1));

    last_rd = '0;
    for (int i = 0; i < 13; i++) begin
      do_op(tbl[i].r, tbl[i].w, tbl[i].a, tbl[i].d, tbl[i].be, rd, rsp);
      check($sformatf("tbl%0d resp", i), 64'(rsp), 64'(tbl[i].exp_resp));
      if (tbl[i].r) begin
        check($sformatf("tbl%0d rdata", i), 64'(rd), 64'(tbl[i].exp_rd));
        last_rd = tbl[i].exp_rd;
      end else begin
        check($sformatf("tbl%0d rdata_hold", i), 64'(rd), 64'(last_rd));
      end
    end

    // Fast instance: read held high, accepts every 2 cycles, data 1 later.
    @(negedge clk);
    bus1.read = 1'b1; bus1.address = 8'd0;
    c0 = cyc;
    for (int j = 0; j < 14; j++) begin
      if (j == 12) bus1.read = 1'b0;
      if (!bus1.waitrequest) accs.push_back(cyc);
      if (bus1.readdatavalid) rdvs.push_back(cyc);
      @(negedge clk);
    end
    check("fast_accepts", 64'(accs.size()), 64'(6));
    check("fast_rdvs", 64'(rdvs.size()), 64'(6));
    if (accs.size() > 0)
      check("fast_first_accept", 64'(accs[0] - c0), 64'(1));
    for (int j = 1; j < accs.size(); j++)
      check("fast_period", 64'(accs[j] - accs[j-1]), 64'(2));
    for (int j = 0; j < accs.size() && j < rdvs.size(); j++)
      check("fast_rd_lat", 64'(rdvs[j] - accs[j]), 64'(1));

    for (int i = 0; i < 150; i++) begin
      kind = $urandom_range(0, 9);
      if ($urandom_range(0, 7) == 0) a = 8'($urandom);
      else a = 8'($urandom_range(0, 17));
      r = (kind < 4) || (kind >= 8);
      w = (kind >= 4) && (kind <= 8);
      if (kind == 9) a = 8'(16 + $urandom_range(0, 1));
      do_op(r, w, a, 32'($urandom), 4'($urandom), rd, rsp);
    end

    // Reset while the slave is stalling in WAIT.
    do_op(1'b0, 1'b1, 8'd1, 32'h1111_1111, 4'hF, rd, rsp);
    @(negedge clk);
    bus0.read = 1'b1; bus0.address = 8'd1;
    @(negedge clk);
    check("wait_stall", 64'(bus0.waitrequest), 64'(1));
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0; bus0.read = 1'b0;
    watch_quiet("rst_in_wait", 10);
    model_reset();
    do_op(1'b1, 1'b0, 8'd16, 32'h0, 4'hF, rd, rsp);
    check("rst_wait_xfer0", 64'(rd), 64'(0));
    do_op(1'b1, 1'b0, 8'd17, 32'h0, 4'hF, rd, rsp);
    check("rst_wait_err0", 64'(rd), 64'(0));
    for (int i = 0; i < 16; i++)
      do_op(1'b1, 1'b0, 8'(i), 32'h0, 4'hF, rd, rsp);
    do_op(1'b1, 1'b0, 8'd1, 32'h0, 4'hF, rd, rsp);
    check("rst_wait_reg1", 64'(rd), 64'(0));

    // Reset one cycle after a read is accepted: response must vanish.
    do_op(1'b0, 1'b1, 8'd5, 32'h0000_0055, 4'hF, rd, rsp);
    @(negedge clk);
    bus0.read = 1'b1; bus0.address = 8'd5;
    k = 0;
    while (bus0.waitrequest && k < 40) begin
      @(negedge clk); k++;
    end
    check("pipe_rst_accept", 64'(bus0.waitrequest), 64'(0));
    @(negedge clk);
    bus0.read = 1'b0; reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    watch_quiet("rst_in_pipe", 8);
    model_reset();
    do_op(1'b1, 1'b0, 8'd16, 32'h0, 4'hF, rd, rsp);
    check("rst_pipe_xfer0", 64'(rd), 64'(0));
    do_op(1'b1, 1'b0, 8'd5, 32'h0, 4'hF, rd, rsp);
    check("rst_pipe_reg5", 64'(rd), 64'(0));

    do_reset();
    for (int i = 0; i < 20; i++)
      do_op(1'b0, 1'b1, 8'($urandom_range(0, 15)), 32'($urandom),
            4'($urandom), rd, rsp);
    do_op(1'b1, 1'b0, 8'd16, 32'h0, 4'hF, rd, rsp);
    check("xfer_after_20", 64'(rd), 64'(20));

    // Read dropped during WAIT: no accept, count unaffected.
    @(negedge clk);
    bus0.read = 1'b1; bus0.address = 8'd3;
    @(negedge clk);
    bus0.read = 1'b0;
    watch_quiet("abort", 8);
    do_op(1'b1, 1'b0, 8'd16, 32'h0, 4'hF, rd, rsp);
    check("xfer_after_abort", 64'(rd), 64'(21));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
